// File: rtl/main_memory_block_if.sv
// Block-granular bus between the data cache miss/write-back port and main memory.
// The cache is the master; the memory responder is the slave.
interface main_memory_block_if;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_address;
  logic [127:0] mem_writedata;
  logic [127:0] mem_readdata;
  logic         mem_busywait;
  logic         access_error;

  modport master (
    output mem_read,
    output mem_write,
    output mem_address,
    output mem_writedata,
    input  mem_readdata,
    input  mem_busywait,
    input  access_error
  );

  modport slave (
    input  mem_read,
    input  mem_write,
    input  mem_address,
    input  mem_writedata,
    output mem_readdata,
    output mem_busywait,
    output access_error
  );
endinterface

// File: rtl/main_memory_block.sv
// Fixed-latency 128-bit block memory behind the data cache, with a busywait handshake.
// Requests are latched in IDLE, counted down in BUSY, and completed with a one-cycle DONE.
module main_memory_block #(
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 4
) (
  input logic clock,
  input logic reset,
  main_memory_block_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam logic [3:0] COUNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t                 r_state;
  state_t                 w_nextState;
  logic [3:0]             r_counter;
  logic                   r_opWrite;
  logic [ADDR_BITS-1:0]   r_index;
  logic [127:0]           r_data;
  logic [127:0]           r_readdata;
  logic                   r_accessError;
  logic [127:0]           r_array [DEPTH];

  logic w_reqOne;
  logic w_reqBoth;
  logic w_busy;
  logic w_accept;
  logic w_commit;
  logic w_error;
  logic w_unusedAddrBits;

  assign w_reqOne  = bus.mem_read ^ bus.mem_write;
  assign w_reqBoth = bus.mem_read & bus.mem_write;

  // Upper block-address bits alias onto the decoded range.
  assign w_unusedAddrBits = ^bus.mem_address[27:ADDR_BITS];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_busy      = 1'b0;
    w_accept    = 1'b0;
    w_commit    = 1'b0;
    w_error     = 1'b0;
    case (r_state)
      IDLE: begin
        w_busy  = w_reqOne;
        w_error = w_reqBoth;
        if (w_reqOne) begin
          w_accept    = 1'b1;
          w_nextState = BUSY;
        end
      end
      BUSY: begin
        w_busy = 1'b1;
        if (r_counter == 4'd0) begin
          w_commit    = 1'b1;
          w_nextState = DONE;
        end
      end
      DONE: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Request latch and countdown; inputs are only sampled on acceptance.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_counter     <= 4'd0;
      r_opWrite     <= 1'b0;
      r_index       <= '0;
      r_data        <= '0;
      r_accessError <= 1'b0;
    end else begin
      r_accessError <= w_error;
      if (w_accept) begin
        r_counter <= COUNT_LOAD;
        r_opWrite <= bus.mem_write;
        r_index   <= bus.mem_address[ADDR_BITS-1:0];
        r_data    <= bus.mem_writedata;
      end else if (r_state == BUSY && r_counter != 4'd0) begin
        r_counter <= r_counter - 4'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_array[i] <= '0;
      end
      r_readdata <= '0;
    end else if (w_commit) begin
      if (r_opWrite) begin
        r_array[r_index] <= r_data;
      end else begin
        r_readdata <= r_array[r_index];
      end
    end
  end

  // Busywait is forced low while reset is held so an aborted op never looks pending.
  assign bus.mem_busywait = w_busy & ~reset;
  assign bus.mem_readdata = r_readdata;
  assign bus.access_error = r_accessError;

endmodule

// File: tb/tb_main_memory_block.sv
// Directed bench for main_memory_block with a cycle-indexed transaction model
// checked against the DUT on every negedge.
module tb_main_memory_block;

  localparam int ADDR_BITS = 8;
  localparam int LAT       = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;

  main_memory_block_if memBus ();

  main_memory_block #(.ADDR_BITS(ADDR_BITS), .LATENCY(LAT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (memBus)
  );

  always #5 clock = ~clock;

  int assertCount = 0;
  int failCount   = 0;
  bit checking    = 1'b0;

  // Model: operation timeline expressed as absolute cycle numbers.
  logic [127:0] tbMem [256];
  logic [127:0] expReaddata = '0;
  logic         expErr      = 1'b0;
  int           cyc         = 0;
  int           freeFrom    = 0;
  int           doneCycle   = -1;
  int           commitCycle = -1;
  logic         opWrite     = 1'b0;
  logic [7:0]   opIdx       = '0;
  logic [127:0] opData      = '0;

  localparam logic [127:0] D1   = 128'h11112222_33334444_55556666_77778888;
  localparam logic [127:0] DA5  = {16{8'hA5}};
  localparam logic [127:0] DBEE = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
  localparam logic [127:0] DCAF = 128'hCAFEBABE_CAFEBABE_CAFEBABE_CAFEBABE;
  localparam logic [127:0] D04  = 128'h04040404_04040404_04040404_04040404;
  localparam logic [127:0] D20  = 128'h20202020_A0A0A0A0_20202020_A0A0A0A0;

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, cyc, actual, expected);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) tbMem[i] = '0;
    forever begin
      @(posedge clock);
      if (reset) begin
        for (int i = 0; i < 256; i++) tbMem[i] = '0;
        expReaddata = '0;
        expErr      = 1'b0;
        freeFrom    = cyc + 1;
        doneCycle   = -1;
        commitCycle = -1;
      end else begin
        expErr = 1'b0;
        if (cyc == commitCycle) begin
          if (opWrite) tbMem[opIdx] = opData;
          else         expReaddata = tbMem[opIdx];
        end
        if (cyc >= freeFrom) begin
          if (memBus.mem_read ^ memBus.mem_write) begin
            opWrite     = memBus.mem_write;
            opIdx       = memBus.mem_address[7:0];
            opData      = memBus.mem_writedata;
            commitCycle = cyc + LAT;
            doneCycle   = cyc + LAT + 1;
            freeFrom    = cyc + LAT + 2;
          end else if (memBus.mem_read && memBus.mem_write) begin
            expErr = 1'b1;
          end
        end
      end
      cyc++;
    end
  end

  initial begin
    logic expBusy;
    forever begin
      @(negedge clock);
      if (checking) begin
        if (reset)                 expBusy = 1'b0;
        else if (cyc < freeFrom)   expBusy = (cyc != doneCycle);
        else                       expBusy = memBus.mem_read ^ memBus.mem_write;
        checkOutput("busywait", {127'd0, memBus.mem_busywait}, {127'd0, expBusy});
        checkOutput("accessError", {127'd0, memBus.access_error}, {127'd0, reset ? 1'b0 : expErr});
        checkOutput("readdata", memBus.mem_readdata, reset ? 128'd0 : expReaddata);
      end
    end
  end

  // Drives one request, optionally changing inputs at cycle changeAt, until busywait drops.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [27:0] addr,
                               input logic [127:0] data, input int changeAt,
                               input logic altRd, input logic altWr, input logic [27:0] altAddr,
                               input logic [127:0] altData, output int busyCycles);
    bit doneSeen;
    doneSeen   = 1'b0;
    busyCycles = 0;
    memBus.mem_read      = rd;
    memBus.mem_write     = wr;
    memBus.mem_address   = addr;
    memBus.mem_writedata = data;
    for (int k = 0; k < 40 && !doneSeen; k++) begin
      if (k == changeAt) begin
        memBus.mem_read      = altRd;
        memBus.mem_write     = altWr;
        memBus.mem_address   = altAddr;
        memBus.mem_writedata = altData;
      end
      @(negedge clock);
      if (!memBus.mem_busywait) doneSeen = 1'b1;
      else                      busyCycles++;
      @(posedge clock);
      #1;
    end
    if (!doneSeen) begin
      failCount++;
      assertCount++;
      $display("[TB] FAIL completionTimeout: busywait still high after 40 cycles, required low");
    end
    memBus.mem_read  = 1'b0;
    memBus.mem_write = 1'b0;
  endtask

  task automatic simpleOp(input logic wr, input logic [27:0] addr, input logic [127:0] data,
                          input string name);
    int busyCycles;
    applyStimulus(~wr, wr, addr, data, -1, ~wr, wr, addr, data, busyCycles);
    checkOutput(name, 128'(busyCycles), 128'd5);
  endtask

  initial begin
    int busyCycles;
    memBus.mem_read      = 1'b0;
    memBus.mem_write     = 1'b0;
    memBus.mem_address   = '0;
    memBus.mem_writedata = '0;
    repeat (3) @(posedge clock);
    #1;
    reset    = 1'b0;
    checking = 1'b1;
    @(negedge clock);
    checkOutput("resetBusy", {127'd0, memBus.mem_busywait}, 128'd0);
    checkOutput("resetReaddata", memBus.mem_readdata, 128'd0);
    @(posedge clock);
    #1;

    simpleOp(1'b1, 28'h0000012, D1, "writeLatency");
    checkOutput("readdataAfterWrite", memBus.mem_readdata, 128'd0);
    checkOutput("modelMem12", tbMem[8'h12], D1);

    simpleOp(1'b0, 28'h0000012, '0, "readLatency");
    checkOutput("readBack12", memBus.mem_readdata, D1);

    simpleOp(1'b1, 28'h0000112, DA5, "aliasWrite");
    simpleOp(1'b0, 28'h0000012, '0, "aliasRead");
    checkOutput("aliasData", memBus.mem_readdata, DA5);

    memBus.mem_read  = 1'b1;
    memBus.mem_write = 1'b1;
    @(negedge clock);
    checkOutput("bothHighBusy", {127'd0, memBus.mem_busywait}, 128'd0);
    @(posedge clock);
    #1;
    memBus.mem_read  = 1'b0;
    memBus.mem_write = 1'b0;
    @(negedge clock);
    checkOutput("errorPulse", {127'd0, memBus.access_error}, 128'd1);
    @(posedge clock);
    #1;
    @(negedge clock);
    checkOutput("errorCleared", {127'd0, memBus.access_error}, 128'd0);
    checkOutput("bothHighReaddata", memBus.mem_readdata, DA5);
    @(posedge clock);
    #1;

    memBus.mem_write     = 1'b1;
    memBus.mem_address   = 28'h0000005;
    memBus.mem_writedata = DBEE;
    repeat (2) begin
      @(posedge clock);
      #1;
    end
    reset            = 1'b1;
    memBus.mem_write = 1'b0;
    @(negedge clock);
    checkOutput("abortBusy", {127'd0, memBus.mem_busywait}, 128'd0);
    checkOutput("abortReaddata", memBus.mem_readdata, 128'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    simpleOp(1'b0, 28'h0000005, '0, "readAfterAbort");
    checkOutput("abortedWriteLost", memBus.mem_readdata, 128'd0);

    simpleOp(1'b1, 28'h0000003, DCAF, "writeCafe");
    simpleOp(1'b1, 28'h0000004, D04, "write04");
    applyStimulus(1'b1, 1'b0, 28'h0000003, '0, 2, 1'b1, 1'b0, 28'h0000004, '0, busyCycles);
    checkOutput("midOpLatency", 128'(busyCycles), 128'd5);
    checkOutput("midOpAddrIgnored", memBus.mem_readdata, DCAF);

    applyStimulus(1'b0, 1'b1, 28'h0000020, D20, 1, 1'b0, 1'b0, 28'h0000020, '0, busyCycles);
    checkOutput("droppedWriteLatency", 128'(busyCycles), 128'd5);
    simpleOp(1'b0, 28'h0000020, '0, "readDropped");
    checkOutput("droppedWriteCommitted", memBus.mem_readdata, D20);

    repeat (3) @(posedge clock);
    #1;
    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required test completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/main_memory_block.md
Name: main_memory_block

Overview:
- Block-granular main-memory responder that sits behind the data cache's miss/write-back port.
- Serves 128-bit block reads (refill) and 128-bit block writes (write-back) addressed by 28-bit block address.
- Models fixed multi-cycle latency, with a busywait handshake matching the cache's MEM_READ/MEM_WRITE states.
- Synthesisable behavioural model used in the RV32IM pipeline testbench and FPGA build.

Parameters:
- ADDR_BITS, 8, number of block-address bits decoded; depth = 2**ADDR_BITS blocks of 128 bits.
- LATENCY, 4, busy cycles between request acceptance and completion; legal range 1..15.

Ports:
- clock  input  1  system clock; all state changes on posedge.
- reset  input  1  asynchronous, active-high.
- mem_read  input  1  block read request; held by initiator until busywait low.
- mem_write  input  1  block write request; held by initiator until busywait low.
- mem_address  input  28  block address ({tag,index} of cache line); bits [ADDR_BITS-1:0] index the array, upper bits ignored (aliasing).
- mem_writedata  input  128  block to store on write.
- mem_readdata  output  128  registered block returned on read.
- mem_busywait  output  1  high while a request is pending or in progress.
- access_error  output  1  registered one-cycle pulse on illegal request.

Behaviour:
- Reset: clock and reset are as stated above: reset is asynchronous, active-high; clock is clock.
- On reset assertion:
  - state=IDLE, counter=0, mem_readdata=0, access_error=0, mem_busywait=0.
  - All array blocks cleared to 0.
  - Any in-flight op is aborted; a pending write is NOT committed.
- States: IDLE, BUSY, DONE.
- IDLE:
  - mem_busywait is combinational and equals (mem_read XOR mem_write). It is high in the same cycle the request appears, so the initiator never sees a false completion.
  - At posedge with exactly one request:
    - Latch op, mem_address[ADDR_BITS-1:0] and mem_writedata.
    - counter <= LATENCY-1.
    - Go to BUSY.
  - mem_read and mem_write both high:
    - Not accepted; mem_busywait=0.
    - access_error pulses high for the next cycle.
    - Stay in IDLE.
- BUSY:
  - mem_busywait=1.
  - At posedge with counter!=0: counter decrements.
  - At posedge with counter==0:
    - Write: array[latched_index] <= latched_data.
    - Read: mem_readdata <= array[latched_index].
    - Go to DONE.
- DONE:
  - mem_busywait=0 for exactly one cycle; the initiator samples mem_readdata at this posedge.
  - Unconditionally go to IDLE.
  - A new request in the following cycle is accepted normally; a back-to-back write-back then refill costs no extra gap.
- Latency, counting the request cycle as cycle 0:
  - mem_busywait high in cycles 0..LATENCY.
  - mem_busywait low in cycle LATENCY+1.
  - For a read, mem_readdata is valid from cycle LATENCY+1.
- mem_readdata holds its value until the next read completes; writes never change it.
- Request inputs are ignored outside IDLE:
  - Changes to address or data mid-operation have no effect.
  - Dropping the request mid-operation still completes the latched op (write commits).
- A read of a block written by the immediately preceding write returns the new data.
- No internal bypass is needed, since the write commits before DONE.
- Array is single-ported; at most one access per operation.

Test Plan:
- Reset, then write addr 0x0000012 data 0x11112222_33334444_55556666_77778888 with LATENCY=4 -> busywait high cycles 0..4, low cycle 5; array[0x12] updated; mem_readdata stays 0.
- Read addr 0x0000012 immediately after previous DONE -> busywait high 5 cycles; mem_readdata = 0x11112222_33334444_55556666_77778888 in cycle 5; request dropped next cycle -> busywait 0.
- Aliasing: write 0xA5...A5 (all bytes 0xA5) to addr 0x0000112 with ADDR_BITS=8, then read 0x0000012 -> returns 0xA5A5...A5.
- mem_read and mem_write both high in IDLE for one cycle -> busywait 0, access_error=1 next cycle only, array and mem_readdata unchanged.
- Reset asserted at cycle 2 of a write of 0xDEADBEEF_... to addr 0x05 -> immediate IDLE, busywait 0; subsequent read of 0x05 returns 0.
- Mid-op change: start a read of 0x03 (holding 0xCAFE...), switch mem_address to 0x04 in cycle 2 -> data of 0x03 returned at cycle 5.
